// File: rtl/seg_display_scanner_pkg.sv
// -----------------------------------------------------------------------------
// seg_display_scanner_pkg
//
// Shared definitions for the multiplexed seven-segment scanner:
//   - glyph constants for the 16 hex digits, the separator dash and blank
//     (bit order {dp,g,f,e,d,c,b,a}, active-high, dp always 0)
//   - digit position constants (which board digit shows which value)
//   - scanner FSM state encoding
//   - a helper that turns a digit index into a one-hot (active-high) select
// -----------------------------------------------------------------------------
package seg_display_scanner_pkg;

    // Hex glyphs 0..F
    localparam logic [7:0] SEG_0 = 8'h3F;
    localparam logic [7:0] SEG_1 = 8'h06;
    localparam logic [7:0] SEG_2 = 8'h5B;
    localparam logic [7:0] SEG_3 = 8'h4F;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'h6D;
    localparam logic [7:0] SEG_6 = 8'h7D;
    localparam logic [7:0] SEG_7 = 8'h07;
    localparam logic [7:0] SEG_8 = 8'h7F;
    localparam logic [7:0] SEG_9 = 8'h6F;
    localparam logic [7:0] SEG_A = 8'h77;
    localparam logic [7:0] SEG_B = 8'h7C;
    localparam logic [7:0] SEG_C = 8'h39;
    localparam logic [7:0] SEG_D = 8'h5E;
    localparam logic [7:0] SEG_E = 8'h79;
    localparam logic [7:0] SEG_F = 8'h71;

    // Separator dash (segment g only) and fully dark digit
    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    // Board digit positions
    localparam logic [1:0] DIGIT_RED   = 2'd0;
    localparam logic [1:0] DIGIT_SEP   = 2'd1;
    localparam logic [1:0] DIGIT_CNT   = 2'd2;
    localparam logic [1:0] DIGIT_GREEN = 2'd3;

    // Scanner FSM states
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    // One-hot, active-high select for a digit index; polarity is applied
    // by the caller.
    function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        return oh;
    endfunction

endpackage

// File: rtl/seg_display_scanner_hex_decoder.sv
// -----------------------------------------------------------------------------
// seg7_hex_decoder
//
// Purely combinational 4-bit value to seven-segment glyph lookup.
//
// Ports:
//   value  in  4  hex value 0..F
//   glyph  out 8  {dp,g,f,e,d,c,b,a}, active-high, dp always 0
// -----------------------------------------------------------------------------
module seg7_hex_decoder
    import seg_display_scanner_pkg::*;
(
    input  logic [3:0] value,
    output logic [7:0] glyph
);

    always_comb begin
        glyph = SEG_OFF;
        case (value)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            4'hF: glyph = SEG_F;
            default: glyph = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_display_scanner.sv
// -----------------------------------------------------------------------------
// seg_display_scanner
//
// Multiplexed 4-digit seven-segment driver for the gomoku scoreboard:
//   d0 = red win count, d1 = '-' while counting down, d2 = countdown value,
//   d3 = green win count.
// Each scan_clk rising edge blanks all digits for BLANK_CYCLES clk cycles
// (anti-ghosting) and then lights the next digit. A digit's glyph is captured
// when its blanking period starts, so input changes while it is lit are not
// seen until its next turn. The countdown digit flashes with flicker_clk when
// three seconds or fewer remain.
//
// Parameters:
//   BLANK_CYCLES    1..15  all-off cycles after each digit switch
//   COM_ACTIVE_LOW  1: digit_sel active-low, 0: active-high
//
// Ports:
//   clk              in   system clock
//   rst_n            in   asynchronous reset, active low
//   en               in   display enable (tie to sw_power)
//   scan_clk         in   slow digit-scan clock, asynchronous to clk
//   flicker_clk      in   flash clock, asynchronous to clk
//   red_win_count    in 4 shown on d0
//   countdown_en     in   high while a player is choosing a move
//   num_countdown    in 4 shown on d2
//   green_win_count  in 4 shown on d3
//   digit_sel        out 4 one-hot digit enable, polarity per COM_ACTIVE_LOW
//   seg_out          out 8 {dp,g,f,e,d,c,b,a}, active-high
// -----------------------------------------------------------------------------
module seg_display_scanner
    import seg_display_scanner_pkg::*;
#(
    parameter int BLANK_CYCLES   = 2,
    parameter bit COM_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       scan_clk,
    input  logic       flicker_clk,
    input  logic [3:0] red_win_count,
    input  logic       countdown_en,
    input  logic [3:0] num_countdown,
    input  logic [3:0] green_win_count,
    output logic [3:0] digit_sel,
    output logic [7:0] seg_out
);

    localparam logic [3:0] SEL_IDLE   = COM_ACTIVE_LOW ? 4'b1111 : 4'b0000;
    localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYCLES - 1);

    // Synchronizers and edge detect
    logic scan_meta;
    logic scan_sync;
    logic scan_prev;
    logic scan_edge;
    logic flick_meta;
    logic flick_sync;

    // FSM and datapath
    scan_state_t state;
    scan_state_t state_nxt;
    logic [1:0]  digit_idx;
    logic [1:0]  idx_nxt;
    logic [3:0]  blank_cnt;
    logic [3:0]  blank_cnt_nxt;
    logic        snapshot_take;
    logic [3:0]  dec_value;
    logic [7:0]  dec_glyph;
    logic [7:0]  snap_nxt;
    logic [7:0]  snap_seg;
    logic        flash_off;
    logic [3:0]  sel_nxt;
    logic [7:0]  seg_nxt;

    // Both asynchronous clocks go through two flops. The scan edge pulse is
    // registered once more so a scan edge reaches the FSM one cycle after the
    // synchronized level rises; a pulse that lands outside SHOW is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_meta  <= 1'b0;
            scan_sync  <= 1'b0;
            scan_prev  <= 1'b0;
            scan_edge  <= 1'b0;
            flick_meta <= 1'b0;
            flick_sync <= 1'b0;
        end else begin
            scan_meta  <= scan_clk;
            scan_sync  <= scan_meta;
            scan_prev  <= scan_sync;
            scan_edge  <= scan_sync & ~scan_prev;
            flick_meta <= flicker_clk;
            flick_sync <= flick_meta;
        end
    end

    // State register. Outputs are registered from their next values so that
    // digit_sel and seg_out always change together on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_OFF;
            digit_idx <= DIGIT_RED;
            blank_cnt <= 4'd0;
            snap_seg  <= SEG_OFF;
            digit_sel <= SEL_IDLE;
            seg_out   <= SEG_OFF;
        end else begin
            state     <= state_nxt;
            digit_idx <= idx_nxt;
            blank_cnt <= blank_cnt_nxt;
            if (snapshot_take) begin
                snap_seg <= snap_nxt;
            end
            digit_sel <= sel_nxt;
            seg_out   <= seg_nxt;
        end
    end

    // Next-state logic. Dropping en forces OFF from anywhere and rewinds the
    // scan to d0. Entering BLANK loads the dead-time counter and marks the
    // cycle on which the upcoming digit's glyph is captured.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = digit_idx;
        blank_cnt_nxt = blank_cnt;

        case (state)
            ST_OFF: begin
                if (en) begin
                    state_nxt = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (!en) begin
                    state_nxt = ST_OFF;
                end else if (blank_cnt == 4'd0) begin
                    state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (!en) begin
                    state_nxt = ST_OFF;
                end else if (scan_edge) begin
                    state_nxt = ST_BLANK;
                    idx_nxt   = digit_idx + 2'd1;
                end
            end
            default: begin
                state_nxt = ST_OFF;
            end
        endcase

        if (state_nxt == ST_OFF) begin
            idx_nxt = DIGIT_RED;
        end

        snapshot_take = (state_nxt == ST_BLANK) && (state != ST_BLANK);

        if (state_nxt == ST_OFF) begin
            blank_cnt_nxt = 4'd0;
        end else if (snapshot_take) begin
            blank_cnt_nxt = BLANK_LOAD;
        end else if ((state == ST_BLANK) && (blank_cnt != 4'd0)) begin
            blank_cnt_nxt = blank_cnt - 4'd1;
        end
    end

    // The single decoder always looks at the digit about to be shown, so its
    // output is exactly what must be captured on BLANK entry. The separator
    // and countdown digits stay dark when no countdown is running.
    always_comb begin
        dec_value = 4'h0;
        case (idx_nxt)
            DIGIT_RED:   dec_value = red_win_count;
            DIGIT_CNT:   dec_value = num_countdown;
            DIGIT_GREEN: dec_value = green_win_count;
            default:     dec_value = 4'h0;
        endcase

        snap_nxt = dec_glyph;
        case (idx_nxt)
            DIGIT_SEP: snap_nxt = countdown_en ? SEG_DASH : SEG_OFF;
            DIGIT_CNT: snap_nxt = countdown_en ? dec_glyph : SEG_OFF;
            default:   snap_nxt = dec_glyph;
        endcase
    end

    seg7_hex_decoder u_hex_decoder (
        .value (dec_value),
        .glyph (dec_glyph)
    );

    // Output logic. Only SHOW lights a digit. The flash gate uses the live
    // countdown inputs rather than the snapshot, so it reacts within a cycle
    // of the countdown dropping to three, while the digit select stays on.
    always_comb begin
        flash_off = (digit_idx == DIGIT_CNT) && countdown_en
                    && (num_countdown <= 4'd3) && !flick_sync;

        sel_nxt = SEL_IDLE;
        seg_nxt = SEG_OFF;
        if (state_nxt == ST_SHOW) begin
            sel_nxt = COM_ACTIVE_LOW ? ~digit_onehot(digit_idx)
                                     : digit_onehot(digit_idx);
            seg_nxt = flash_off ? SEG_OFF : snap_seg;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scanner
//
// Self-checking bench for seg_display_scanner. dut1 uses the defaults
// (BLANK_CYCLES=2, active-low selects); dut2 uses BLANK_CYCLES=4 with
// active-high selects.
// -----------------------------------------------------------------------------
module tb_seg_display_scanner;

    localparam int B1 = 2;
    localparam int B2 = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       en2;
    logic       scan;
    logic       scan2;
    logic       flicker;
    logic [3:0] red;
    logic       cden;
    logic [3:0] num;
    logic [3:0] green;
    logic [3:0] dig_sel;
    logic [7:0] seg;
    logic [3:0] dig_sel2;
    logic [7:0] seg2;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] num;
        logic       cden;
        logic [3:0] exp_sel;
        logic [7:0] exp_seg;
    } vec_t;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] seg;
        int         blank;
    } exp_t;

    exp_t sb[$];
    vec_t rows[14];

    logic [3:0] prev_sel;
    logic [7:0] prev_seg;

    seg_display_scanner #(.BLANK_CYCLES(B1), .COM_ACTIVE_LOW(1'b1)) dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .scan_clk        (scan),
        .flicker_clk     (flicker),
        .red_win_count   (red),
        .countdown_en    (cden),
        .num_countdown   (num),
        .green_win_count (green),
        .digit_sel       (dig_sel),
        .seg_out         (seg)
    );

    seg_display_scanner #(.BLANK_CYCLES(B2), .COM_ACTIVE_LOW(1'b0)) dut2 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en2),
        .scan_clk        (scan2),
        .flicker_clk     (flicker),
        .red_win_count   (red),
        .countdown_en    (cden),
        .num_countdown   (num),
        .green_win_count (green),
        .digit_sel       (dig_sel2),
        .seg_out         (seg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name,
                               input logic [3:0] act_sel, input logic [7:0] act_seg,
                               input logic [3:0] exp_sel, input logic [7:0] exp_seg);
        tests++;
        if (act_sel !== exp_sel || act_seg !== exp_seg) begin
            failed++;
            $display("[TB] FAIL %s: got sel=%b seg=%h, expected sel=%b seg=%h",
                     name, act_sel, act_seg, exp_sel, exp_seg);
        end
    endtask

    // Scoreboard monitor for dut1: every time a digit lights up after a dark
    // period, the oldest expectation is popped and compared, including the
    // length of the dark period when the expectation asks for it.
    logic mon_prev_on = 1'b0;
    int   mon_off_run = 0;
    always @(negedge clk) begin
        logic on;
        exp_t e;
        on = (dig_sel != 4'b1111);
        if (!rst_n) begin
            mon_prev_on = 1'b0;
            mon_off_run = 0;
        end else begin
            if (on && !mon_prev_on) begin
                if (sb.size() == 0) begin
                    tests++;
                    failed++;
                    $display("[TB] FAIL unexpected_digit: got sel=%b seg=%h, expected no digit",
                             dig_sel, seg);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sb_digit", dig_sel, seg, e.sel, e.seg);
                    if (e.blank != 0) begin
                        tests++;
                        if (mon_off_run != e.blank) begin
                            failed++;
                            $display("[TB] FAIL sb_blank_len: got %0d dark cycles, expected %0d",
                                     mon_off_run, e.blank);
                        end
                    end
                end
                mon_off_run = 0;
            end else if (!on) begin
                mon_off_run = mon_off_run + 1;
            end
            mon_prev_on = on;
        end
    end

    // One table row: change inputs while the current digit is lit (it must
    // not react), queue the next digit, pulse scan and check edge-to-blank
    // latency; the monitor checks the digit once it appears.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        red   = v.red;
        green = v.green;
        num   = v.num;
        cden  = v.cden;
        tick(1);
        checkOutput("hold", dig_sel, seg, prev_sel, prev_seg);
        e.sel   = v.exp_sel;
        e.seg   = v.exp_seg;
        e.blank = B1;
        sb.push_back(e);
        scan = 1'b1;
        tick(3);
        checkOutput("pre_blank", dig_sel, seg, prev_sel, prev_seg);
        tick(1);
        checkOutput("blank_start", dig_sel, seg, 4'b1111, 8'h00);
        scan = 1'b0;
        tick(B1);
        prev_sel = v.exp_sel;
        prev_seg = v.exp_seg;
    endtask

    initial begin
        exp_t e;

        //          red    green  num    cden  sel      seg
        rows[0]  = '{4'd2,  4'd5,  4'd0, 1'b0, 4'b1101, 8'h00};
        rows[1]  = '{4'd2,  4'd5,  4'd0, 1'b0, 4'b1011, 8'h00};
        rows[2]  = '{4'd2,  4'd5,  4'd0, 1'b0, 4'b0111, 8'h6D};
        rows[3]  = '{4'd2,  4'd5,  4'd0, 1'b0, 4'b1110, 8'h5B};
        rows[4]  = '{4'd2,  4'd5,  4'd9, 1'b1, 4'b1101, 8'h40};
        rows[5]  = '{4'd2,  4'd5,  4'd9, 1'b1, 4'b1011, 8'h6F};
        rows[6]  = '{4'd2,  4'd5,  4'd8, 1'b1, 4'b0111, 8'h6D};
        rows[7]  = '{4'd2,  4'd5,  4'd8, 1'b1, 4'b1110, 8'h5B};
        rows[8]  = '{4'd2,  4'd5,  4'd8, 1'b1, 4'b1101, 8'h40};
        rows[9]  = '{4'd2,  4'd5,  4'd8, 1'b1, 4'b1011, 8'h7F};
        rows[10] = '{4'd15, 4'd10, 4'd8, 1'b1, 4'b0111, 8'h77};
        rows[11] = '{4'd15, 4'd10, 4'd8, 1'b1, 4'b1110, 8'h71};
        rows[12] = '{4'd15, 4'd10, 4'd8, 1'b0, 4'b1101, 8'h00};
        rows[13] = '{4'd15, 4'd10, 4'd3, 1'b1, 4'b1011, 8'h4F};

        rst_n   = 1'b0;
        en      = 1'b0;
        en2     = 1'b0;
        scan    = 1'b0;
        scan2   = 1'b0;
        flicker = 1'b1;
        red     = 4'd2;
        green   = 4'd5;
        cden    = 1'b0;
        num     = 4'd0;
        tick(3);
        checkOutput("reset_dut1", dig_sel, seg, 4'b1111, 8'h00);
        checkOutput("reset_dut2", dig_sel2, seg2, 4'b0000, 8'h00);
        rst_n = 1'b1;
        tick(1);

        // Enable: d0 appears after the dark period
        e = '{4'b1110, 8'h5B, 0};
        sb.push_back(e);
        en = 1'b1;
        tick(B1);
        checkOutput("enable_dark", dig_sel, seg, 4'b1111, 8'h00);
        tick(1);
        checkOutput("first_digit", dig_sel, seg, 4'b1110, 8'h5B);
        prev_sel = 4'b1110;
        prev_seg = 8'h5B;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(rows[i]);
        end

        // Flash on d2 (countdown 3): follows flicker with a 3-cycle lag
        for (int k = 0; k < 2; k++) begin
            flicker = 1'b0;
            tick(2);
            checkOutput("flash_lag_on", dig_sel, seg, 4'b1011, 8'h4F);
            tick(1);
            checkOutput("flash_dark", dig_sel, seg, 4'b1011, 8'h00);
            flicker = 1'b1;
            tick(2);
            checkOutput("flash_lag_off", dig_sel, seg, 4'b1011, 8'h00);
            tick(1);
            checkOutput("flash_lit", dig_sel, seg, 4'b1011, 8'h4F);
        end

        // Drop en while d2 is lit, then re-enable: d0 comes first
        en = 1'b0;
        tick(1);
        checkOutput("en_drop", dig_sel, seg, 4'b1111, 8'h00);
        tick(3);
        e = '{4'b1110, 8'h71, 0};
        sb.push_back(e);
        en = 1'b1;
        tick(B1);
        checkOutput("reenable_dark", dig_sel, seg, 4'b1111, 8'h00);
        tick(1);
        checkOutput("reenable_d0", dig_sel, seg, 4'b1110, 8'h71);

        // Asynchronous reset in the middle of a blanking period
        scan = 1'b1;
        tick(4);
        checkOutput("blank_before_reset", dig_sel, seg, 4'b1111, 8'h00);
        #2;
        rst_n = 1'b0;
        scan  = 1'b0;
        #1;
        checkOutput("reset_mid_blank", dig_sel, seg, 4'b1111, 8'h00);
        @(posedge clk);
        #1;
        checkOutput("reset_held", dig_sel, seg, 4'b1111, 8'h00);
        e = '{4'b1110, 8'h71, 0};
        sb.push_back(e);
        rst_n = 1'b1;
        tick(B1);
        checkOutput("post_reset_dark", dig_sel, seg, 4'b1111, 8'h00);
        tick(1);
        checkOutput("post_reset_d0", dig_sel, seg, 4'b1110, 8'h71);

        // Asynchronous reset while a digit is lit takes effect before any edge
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_show", dig_sel, seg, 4'b1111, 8'h00);
        en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);

        // dut2: BLANK_CYCLES=4, active-high selects
        red   = 4'd15;
        green = 4'd10;
        cden  = 1'b0;
        en2   = 1'b1;
        tick(B2);
        checkOutput("dut2_enable_dark", dig_sel2, seg2, 4'b0000, 8'h00);
        tick(1);
        checkOutput("dut2_d0", dig_sel2, seg2, 4'b0001, 8'h71);

        // Two scan edges 3 cycles apart: the second lands in BLANK
        scan2 = 1'b1;
        tick(1);
        scan2 = 1'b0;
        tick(2);
        scan2 = 1'b1;
        tick(1);
        checkOutput("dut2_blank", dig_sel2, seg2, 4'b0000, 8'h00);
        tick(B2);
        checkOutput("dut2_d1", dig_sel2, seg2, 4'b0010, 8'h00);
        tick(1);
        scan2 = 1'b0;
        tick(6);
        checkOutput("dut2_second_edge_ignored", dig_sel2, seg2, 4'b0010, 8'h00);

        scan2 = 1'b1;
        tick(4);
        scan2 = 1'b0;
        tick(B2);
        checkOutput("dut2_d2", dig_sel2, seg2, 4'b0100, 8'h00);
        scan2 = 1'b1;
        tick(4);
        scan2 = 1'b0;
        tick(B2);
        checkOutput("dut2_d3", dig_sel2, seg2, 4'b1000, 8'h77);

        // Every queued digit must have been seen
        tick(5);
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending digits, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
